mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_pkg.sv | 23 ++
 rtl/mem_arb_tag_pipe.sv | 31 +++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared widths and state/tag types for the single-port RAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;

    // CPU access tracker: grant edge -> RAM addressed -> data returned.
    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_MEM  = 2'd1,
        C_RET  = 2'd2
    } cpu_state_t;

    // Owner of the access travelling from grant to return.
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_CPU  = 2'd1,
        TAG_VGA  = 2'd2
    } tag_t;

endpackage

// File: rtl/mem_arb_tag_pipe.sv
// Two-stage delay line carrying the grant owner tag to the return edge.
// Latency: 2 cycles from tag_in to tag_out.
// Backpressure: none; shifts every cycle, synchronous reset empties both stages.
//
// Ports: clk, reset (sync, active-low), tag_in (owner granted this edge),
//        tag_out (owner whose RAM data is on mem_rdata this cycle).
module mem_arb_tag_pipe
    import mem_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stage1;
    tag_t stage2;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stage1 <= TAG_NONE;
            stage2 <= TAG_NONE;
        end else begin
            stage1 <= tag_in;
            stage2 <= stage1;
        end
    end

    assign tag_out = stage2;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port RAM between a CPU port and a streaming VGA read port.
// Latency: grant at E0, ack/valid pulse and read data registered at E2.
// Backpressure: CPU holds cpu_req until cpu_ack; VGA is never stalled except by
//               a CPU win after MAX_VGA_BURST contended grants or enable low.
//
// Ports: clk, reset (sync, active-low), enable (gates new grants);
//        CPU: cpu_req/cpu_addr/cpu_we/cpu_wdata in, cpu_ack/cpu_rdata out;
//        VGA: vga_req/vga_addr in, vga_valid/vga_rdata out;
//        RAM: mem_addr/mem_we/mem_wdata out (registered), mem_rdata in.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int MAX_VGA_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_valid,
    output logic [DATA_W-1:0] vga_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int STREAK_W = $clog2(MAX_VGA_BURST + 1);

    cpu_state_t          cpu_state;
    cpu_state_t          cpu_state_nxt;
    logic                cpu_ack_nxt;
    logic                cpu_wr_q;     // direction of the outstanding CPU access
    logic [STREAK_W-1:0] vga_streak;
    logic                streak_full;
    logic                cpu_want;
    logic                grant_cpu;
    logic                grant_vga;
    tag_t                grant_tag;
    tag_t                ret_tag;

    // CPU may only compete while it has nothing outstanding.
    assign cpu_want    = cpu_req && (cpu_state == C_IDLE);
    assign streak_full = (vga_streak == STREAK_W'(MAX_VGA_BURST));

    always_comb begin
        grant_cpu = 1'b0;
        grant_vga = 1'b0;
        if (enable) begin
            if (cpu_want && vga_req) begin
                // VGA wins contention until it has starved the CPU long enough.
                if (streak_full) begin
                    grant_cpu = 1'b1;
                end else begin
                    grant_vga = 1'b1;
                end
            end else if (cpu_want) begin
                grant_cpu = 1'b1;
            end else if (vga_req) begin
                grant_vga = 1'b1;
            end
        end
    end

    always_comb begin
        grant_tag = TAG_NONE;
        if (grant_cpu) begin
            grant_tag = TAG_CPU;
        end else if (grant_vga) begin
            grant_tag = TAG_VGA;
        end
    end

    mem_arb_tag_pipe u_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .tag_in  (grant_tag),
        .tag_out (ret_tag)
    );

    // CPU FSM: the ack is produced on leaving C_RET, so the CPU becomes
    // eligible again on the edge after the ack pulse.
    always_comb begin
        cpu_state_nxt = cpu_state;
        cpu_ack_nxt   = 1'b0;
        case (cpu_state)
            C_IDLE: if (grant_cpu) cpu_state_nxt = C_MEM;
            C_MEM:  cpu_state_nxt = C_RET;
            C_RET: begin
                cpu_state_nxt = C_IDLE;
                cpu_ack_nxt   = 1'b1;
            end
            default: cpu_state_nxt = C_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cpu_state  <= C_IDLE;
            cpu_ack    <= 1'b0;
            cpu_rdata  <= '0;
            cpu_wr_q   <= 1'b0;
            vga_valid  <= 1'b0;
            vga_rdata  <= '0;
            vga_streak <= '0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
        end else begin
            cpu_state <= cpu_state_nxt;
            cpu_ack   <= cpu_ack_nxt;
            mem_we    <= grant_cpu && cpu_we;

            if (grant_cpu) begin
                mem_addr  <= cpu_addr;
                mem_wdata <= cpu_wdata;
                cpu_wr_q  <= cpu_we;
            end else if (grant_vga) begin
                mem_addr  <= vga_addr;
            end

            // Writes still ack but leave the last read data in place.
            if (cpu_ack_nxt && !cpu_wr_q) begin
                cpu_rdata <= mem_rdata;
            end

            vga_valid <= (ret_tag == TAG_VGA);
            if (ret_tag == TAG_VGA) begin
                vga_rdata <= mem_rdata;
            end

            // Streak only measures how long a waiting CPU has been passed over.
            if (grant_cpu || !cpu_req) begin
                vga_streak <= '0;
            end else if (grant_vga && cpu_want && !streak_full) begin
                vga_streak <= vga_streak + 1'b1;
            end
        end
    end

endmodule
